// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int REG_COUNT_DEF = 8;
   localparam int IDX_W_DEF     = $clog2(REG_COUNT_DEF);

   typedef logic [IDX_W_DEF-1:0] idx_t;

   // busy_count must be able to hold REG_COUNT itself, hence the +1.
   function automatic int cnt_width(input int reg_count);
      return $clog2(reg_count + 1);
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/issue and writeback bus of the register file: read, write, alloc and flush groups.
interface regfile_mp_if
   import regfile_mp_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1
) ();

   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int CNT_W = cnt_width(REG_COUNT);

   logic [NUM_RD-1:0][IDX_W-1:0] rd_idx;
   logic [NUM_RD-1:0][XLEN-1:0]  rd_data;
   logic [NUM_RD-1:0]            rd_busy;

   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR-1:0][IDX_W-1:0] wr_idx;
   logic [NUM_WR-1:0][XLEN-1:0]  wr_data;

   logic                         alloc_en;
   logic [IDX_W-1:0]             alloc_idx;
   logic                         alloc_ready;

   logic                         flush;
   logic [CNT_W-1:0]             busy_count;

   modport master (
      output rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush,
      input  rd_data, rd_busy, alloc_ready, busy_count
   );

   modport slave (
      input  rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, flush,
      output rd_data, rd_busy, alloc_ready, busy_count
   );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, alloc acceptance, flush and a running count.
module rf_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   localparam int IDX_W    = $clog2(REG_COUNT),
   localparam int CNT_W    = cnt_width(REG_COUNT)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR-1:0][IDX_W-1:0] wr_idx,
   input  logic                         alloc_en,
   input  logic [IDX_W-1:0]             alloc_idx,
   input  logic                         flush,
   input  logic [NUM_RD-1:0][IDX_W-1:0] rd_idx,
   output logic [NUM_RD-1:0]            rd_busy,
   output logic                         alloc_ready,
   output logic [CNT_W-1:0]             busy_count
);

   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] busy_nxt;
   logic [REG_COUNT-1:0] clr_mask;
   logic                 alloc_acc;
   logic [CNT_W-1:0]     count_nxt;

   function automatic logic [CNT_W-1:0] popcount(input logic [REG_COUNT-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   // A mask rather than a per-port decrement, so two ports hitting one index clear it once.
   always_comb begin
      clr_mask = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_idx[p] != '0)) begin
            clr_mask[wr_idx[p]] = 1'b1;
         end
      end
   end

   // Readiness looks only at stored busy: a same-cycle write does not enable a re-alloc.
   always_comb begin
      alloc_ready = (alloc_idx == '0) || !busy[alloc_idx];
      alloc_acc   = alloc_en && alloc_ready && (alloc_idx != '0);
   end

   always_comb begin
      busy_nxt = busy & ~clr_mask;
      if (alloc_acc) begin
         busy_nxt[alloc_idx] = 1'b1;
      end
      if (flush) begin
         busy_nxt = '0;
      end
      busy_nxt[0] = 1'b0;
   end

   // An accepted alloc targets a non-busy index, so it never overlaps the cleared set.
   always_comb begin
      if (flush) begin
         count_nxt = '0;
      end else begin
         count_nxt = busy_count + CNT_W'(alloc_acc) - popcount(busy & clr_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_busy[r] = busy[rd_idx[r]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and pending-write scoreboard.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter int BYPASS    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_mp_if.slave   bus
);

   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int CNT_W = cnt_width(REG_COUNT);

   logic [XLEN-1:0]             regs [REG_COUNT];
   logic [NUM_RD-1:0]           sb_busy;
   logic [NUM_RD-1:0][XLEN-1:0] rd_data_c;
   logic [NUM_RD-1:0]           rd_busy_c;
   logic [CNT_W-1:0]            sb_count;
   logic                        sb_ready;

   rf_scoreboard #(
      .REG_COUNT (REG_COUNT),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (bus.wr_en),
      .wr_idx      (bus.wr_idx),
      .alloc_en    (bus.alloc_en),
      .alloc_idx   (bus.alloc_idx),
      .flush       (bus.flush),
      .rd_idx      (bus.rd_idx),
      .rd_busy     (sb_busy),
      .alloc_ready (sb_ready),
      .busy_count  (sb_count)
   );

   // Ports are visited in ascending order so the highest matching port's assignment lands last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && (bus.wr_idx[p] != IDX_W'(0))) begin
               regs[bus.wr_idx[p]] <= bus.wr_data[p];
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_data_c[r] = regs[bus.rd_idx[r]];
         rd_busy_c[r] = sb_busy[r];
         if (BYPASS != 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (bus.wr_en[p] && (bus.wr_idx[p] == bus.rd_idx[r])) begin
                  rd_data_c[r] = bus.wr_data[p];
                  rd_busy_c[r] = 1'b0;
               end
            end
         end
         // x0 is forced last so a bypassed write to it can never leak through.
         if (bus.rd_idx[r] == IDX_W'(0)) begin
            rd_data_c[r] = '0;
            rd_busy_c[r] = 1'b0;
         end
      end
   end

   assign bus.rd_data     = rd_data_c;
   assign bus.rd_busy     = rd_busy_c;
   assign bus.alloc_ready = sb_ready;
   assign bus.busy_count  = sb_count;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances fed identical stimulus, checked against a model.
module tb_regfile_mp;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   regfile_mp_if #(.XLEN(32), .REG_COUNT(8), .NUM_RD(2), .NUM_WR(2)) bus_b ();
   regfile_mp_if #(.XLEN(32), .REG_COUNT(8), .NUM_RD(2), .NUM_WR(2)) bus_n ();

   regfile_mp #(.XLEN(32), .REG_COUNT(8), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   regfile_mp #(.XLEN(32), .REG_COUNT(8), .NUM_RD(2), .NUM_WR(2), .BYPASS(0))
      dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

   assign bus_n.rd_idx    = bus_b.rd_idx;
   assign bus_n.wr_en     = bus_b.wr_en;
   assign bus_n.wr_idx    = bus_b.wr_idx;
   assign bus_n.wr_data   = bus_b.wr_data;
   assign bus_n.alloc_en  = bus_b.alloc_en;
   assign bus_n.alloc_idx = bus_b.alloc_idx;
   assign bus_n.flush     = bus_b.flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural contents and the set of registers with a pending producer.
   logic [31:0] m_regs [8];
   bit          m_busy [8];

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic bit model_ready();
      return (bus_b.alloc_idx == 3'd0) || !m_busy[bus_b.alloc_idx];
   endfunction

   function automatic void model_read(input bit byp, input int port,
                                      output logic [31:0] d, output bit b);
      int idx = int'(bus_b.rd_idx[port]);
      d = m_regs[idx];
      b = m_busy[idx];
      if (byp) begin
         for (int p = 0; p < 2; p++) begin
            if (bus_b.wr_en[p] && int'(bus_b.wr_idx[p]) == idx) begin
               d = bus_b.wr_data[p];
               b = 1'b0;
            end
         end
      end
      if (idx == 0) begin
         d = '0;
         b = 1'b0;
      end
   endfunction

   function automatic void model_clock();
      bit rdy = model_ready();
      for (int p = 0; p < 2; p++) begin
         if (bus_b.wr_en[p] && bus_b.wr_idx[p] != 3'd0) begin
            m_regs[bus_b.wr_idx[p]] = bus_b.wr_data[p];
            m_busy[bus_b.wr_idx[p]] = 1'b0;
         end
      end
      if (bus_b.alloc_en && rdy && bus_b.alloc_idx != 3'd0) m_busy[bus_b.alloc_idx] = 1'b1;
      if (bus_b.flush) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      end
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] d;
      bit          b;
      for (int r = 0; r < 2; r++) begin
         model_read(1'b1, r, d, b);
         chk($sformatf("%s byp rd_data[%0d]", tag, r), 64'(bus_b.rd_data[r]), 64'(d));
         chk($sformatf("%s byp rd_busy[%0d]", tag, r), 64'(bus_b.rd_busy[r]), 64'(b));
         model_read(1'b0, r, d, b);
         chk($sformatf("%s nobyp rd_data[%0d]", tag, r), 64'(bus_n.rd_data[r]), 64'(d));
         chk($sformatf("%s nobyp rd_busy[%0d]", tag, r), 64'(bus_n.rd_busy[r]), 64'(b));
      end
      chk({tag, " alloc_ready"}, 64'(bus_b.alloc_ready), 64'(model_ready()));
      chk({tag, " nobyp alloc_ready"}, 64'(bus_n.alloc_ready), 64'(model_ready()));
      chk({tag, " busy_count"}, 64'(bus_b.busy_count), 64'(model_count()));
      chk({tag, " nobyp busy_count"}, 64'(bus_n.busy_count), 64'(model_count()));
   endtask

   task automatic set_idle();
      bus_b.wr_en     = '0;
      bus_b.wr_idx    = '0;
      bus_b.wr_data   = '0;
      bus_b.alloc_en  = 1'b0;
      bus_b.alloc_idx = '0;
      bus_b.flush     = 1'b0;
      bus_b.rd_idx    = '0;
   endtask

   // Let the edge happen, advance the model, and come back to the low phase.
   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [2:0]  wi0;
      logic [31:0] wd0;
      logic [2:0]  wi1;
      logic [31:0] wd1;
      logic        ae;
      logic [2:0]  ai;
      logic        fl;
      logic [2:0]  ri0;
      logic [2:0]  ri1;
      logic [31:0] e_d0b;
      logic [31:0] e_d1b;
      logic [31:0] e_d1n;
      logic        e_b1b;
      logic        e_b1n;
      logic        e_rdy;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(
      input logic [1:0] we, input logic [2:0] wi0, input logic [31:0] wd0,
      input logic [2:0] wi1, input logic [31:0] wd1,
      input logic ae, input logic [2:0] ai, input logic fl,
      input logic [2:0] ri0, input logic [2:0] ri1,
      input logic [31:0] e_d0b, input logic [31:0] e_d1b, input logic [31:0] e_d1n,
      input logic e_b1b, input logic e_b1n, input logic e_rdy, input logic [3:0] e_cnt);
      vec_t v;
      v.we = we; v.wi0 = wi0; v.wd0 = wd0; v.wi1 = wi1; v.wd1 = wd1;
      v.ae = ae; v.ai = ai; v.fl = fl; v.ri0 = ri0; v.ri1 = ri1;
      v.e_d0b = e_d0b; v.e_d1b = e_d1b; v.e_d1n = e_d1n;
      v.e_b1b = e_b1b; v.e_b1n = e_b1n; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
      return v;
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      //            we    wi0 wd0           wi1 wd1    ae ai fl ri0 ri1  e_d0b         e_d1b         e_d1n         b1b b1n rdy cnt
      tbl[0]  = mk(2'b01, 3, 32'hDEADBEEF, 0, 0,      0, 0, 0, 3, 3,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0, 1, 0);
      tbl[1]  = mk(2'b00, 0, 0,            0, 0,      0, 0, 0, 3, 3,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0);
      tbl[2]  = mk(2'b00, 0, 0,            0, 0,      1, 5, 0, 0, 5,   32'h0,        32'h0,        32'h0,        0, 0, 1, 0);
      tbl[3]  = mk(2'b00, 0, 0,            0, 0,      0, 5, 0, 0, 5,   32'h0,        32'h0,        32'h0,        1, 1, 0, 1);
      tbl[4]  = mk(2'b01, 5, 7,            0, 0,      0, 5, 0, 5, 5,   32'h7,        32'h7,        32'h0,        0, 1, 0, 1);
      tbl[5]  = mk(2'b00, 0, 0,            0, 0,      0, 5, 0, 5, 5,   32'h7,        32'h7,        32'h7,        0, 0, 1, 0);
      tbl[6]  = mk(2'b11, 2, 32'h11,       2, 32'h22, 0, 0, 0, 2, 2,   32'h22,       32'h22,       32'h0,        0, 0, 1, 0);
      tbl[7]  = mk(2'b00, 0, 0,            0, 0,      0, 0, 0, 2, 2,   32'h22,       32'h22,       32'h22,       0, 0, 1, 0);
      tbl[8]  = mk(2'b01, 0, 32'h55,       0, 0,      1, 0, 0, 0, 0,   32'h0,        32'h0,        32'h0,        0, 0, 1, 0);
      tbl[9]  = mk(2'b00, 0, 0,            0, 0,      0, 0, 0, 0, 0,   32'h0,        32'h0,        32'h0,        0, 0, 1, 0);
      tbl[10] = mk(2'b00, 0, 0,            0, 0,      1, 1, 0, 1, 1,   32'h0,        32'h0,        32'h0,        0, 0, 1, 0);
      tbl[11] = mk(2'b00, 0, 0,            0, 0,      1, 4, 0, 1, 1,   32'h0,        32'h0,        32'h0,        1, 1, 1, 1);
      tbl[12] = mk(2'b00, 0, 0,            0, 0,      1, 6, 0, 4, 4,   32'h0,        32'h0,        32'h0,        1, 1, 1, 2);
      tbl[13] = mk(2'b00, 0, 0,            0, 0,      1, 7, 1, 6, 6,   32'h0,        32'h0,        32'h0,        1, 1, 1, 3);
      tbl[14] = mk(2'b00, 0, 0,            0, 0,      0, 7, 0, 3, 7,   32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 1, 0);
      tbl[15] = mk(2'b00, 0, 0,            0, 0,      0, 0, 0, 2, 6,   32'h22,       32'h0,        32'h0,        0, 0, 1, 0);
      tbl[16] = mk(2'b10, 0, 0,            4, 32'h44, 1, 4, 0, 4, 4,   32'h44,       32'h44,       32'h0,        0, 0, 1, 0);
      tbl[17] = mk(2'b00, 0, 0,            0, 0,      0, 4, 0, 4, 4,   32'h44,       32'h44,       32'h44,       1, 1, 0, 1);

      rst_n = 1'b0;
      set_idle();
      model_reset();

      // Reset state seen through every index on both ports.
      #2;
      for (int i = 0; i < 8; i++) begin
         bus_b.rd_idx[0] = 3'(i);
         bus_b.rd_idx[1] = 3'(7 - i);
         #1;
         for (int r = 0; r < 2; r++) begin
            chk($sformatf("reset byp rd_data[%0d] idx%0d", r, i), 64'(bus_b.rd_data[r]), 64'h0);
            chk($sformatf("reset byp rd_busy[%0d] idx%0d", r, i), 64'(bus_b.rd_busy[r]), 64'h0);
            chk($sformatf("reset nobyp rd_data[%0d] idx%0d", r, i), 64'(bus_n.rd_data[r]), 64'h0);
         end
         bus_b.alloc_idx = 3'(i);
         #1;
         chk($sformatf("reset alloc_ready idx%0d", i), 64'(bus_b.alloc_ready), 64'h1);
      end
      chk("reset busy_count", 64'(bus_b.busy_count), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      set_idle();
      @(negedge clk);

      for (int v = 0; v < 18; v++) begin
         bus_b.wr_en      = tbl[v].we;
         bus_b.wr_idx[0]  = tbl[v].wi0;
         bus_b.wr_data[0] = tbl[v].wd0;
         bus_b.wr_idx[1]  = tbl[v].wi1;
         bus_b.wr_data[1] = tbl[v].wd1;
         bus_b.alloc_en   = tbl[v].ae;
         bus_b.alloc_idx  = tbl[v].ai;
         bus_b.flush      = tbl[v].fl;
         bus_b.rd_idx[0]  = tbl[v].ri0;
         bus_b.rd_idx[1]  = tbl[v].ri1;
         #2;
         chk($sformatf("vec%0d byp rd_data[0]", v), 64'(bus_b.rd_data[0]), 64'(tbl[v].e_d0b));
         chk($sformatf("vec%0d byp rd_data[1]", v), 64'(bus_b.rd_data[1]), 64'(tbl[v].e_d1b));
         chk($sformatf("vec%0d nobyp rd_data[1]", v), 64'(bus_n.rd_data[1]), 64'(tbl[v].e_d1n));
         chk($sformatf("vec%0d byp rd_busy[1]", v), 64'(bus_b.rd_busy[1]), 64'(tbl[v].e_b1b));
         chk($sformatf("vec%0d nobyp rd_busy[1]", v), 64'(bus_n.rd_busy[1]), 64'(tbl[v].e_b1n));
         chk($sformatf("vec%0d alloc_ready", v), 64'(bus_b.alloc_ready), 64'(tbl[v].e_rdy));
         chk($sformatf("vec%0d busy_count", v), 64'(bus_b.busy_count), 64'(tbl[v].e_cnt));
         tick();
      end

      // Build up busy_count=2 with x3=9, then pull reset between clock edges.
      set_idle();
      bus_b.wr_en[0]   = 1'b1;
      bus_b.wr_idx[0]  = 3'd3;
      bus_b.wr_data[0] = 32'd9;
      bus_b.alloc_en   = 1'b1;
      bus_b.alloc_idx  = 3'd1;
      #2;
      check_model("pre_rst");
      tick();
      set_idle();
      bus_b.rd_idx[0]  = 3'd3;
      bus_b.rd_idx[1]  = 3'd1;
      bus_b.alloc_idx  = 3'd1;
      #1;
      chk("pre_rst busy_count", 64'(bus_b.busy_count), 64'd2);
      chk("pre_rst x3", 64'(bus_b.rd_data[0]), 64'd9);
      chk("pre_rst x1 busy", 64'(bus_b.rd_busy[1]), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst byp x3", 64'(bus_b.rd_data[0]), 64'd0);
      chk("async_rst nobyp x3", 64'(bus_n.rd_data[0]), 64'd0);
      chk("async_rst x1 busy", 64'(bus_b.rd_busy[1]), 64'd0);
      chk("async_rst busy_count", 64'(bus_b.busy_count), 64'd0);
      chk("async_rst alloc_ready", 64'(bus_b.alloc_ready), 64'd1);
      model_reset();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst x3", 64'(bus_b.rd_data[0]), 64'd0);
      check_model("post_rst");
      @(negedge clk);

      // Randomized traffic against the model.
      for (int c = 0; c < 300; c++) begin
         bus_b.wr_en      = 2'($urandom_range(0, 3));
         bus_b.wr_idx[0]  = 3'($urandom_range(0, 7));
         bus_b.wr_idx[1]  = ($urandom_range(0, 3) == 0) ? bus_b.wr_idx[0] : 3'($urandom_range(0, 7));
         bus_b.wr_data[0] = $urandom;
         bus_b.wr_data[1] = $urandom;
         bus_b.alloc_en   = 1'($urandom_range(0, 1));
         bus_b.alloc_idx  = 3'($urandom_range(0, 7));
         bus_b.flush      = ($urandom_range(0, 15) == 0);
         bus_b.rd_idx[0]  = ($urandom_range(0, 2) == 0) ? bus_b.wr_idx[0] : 3'($urandom_range(0, 7));
         bus_b.rd_idx[1]  = ($urandom_range(0, 2) == 0) ? bus_b.wr_idx[1] : 3'($urandom_range(0, 7));
         #2;
         check_model($sformatf("rand%0d", c));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
